// File: rtl/km_modinv.sv
// ============================================================================
//  Module      : km_modinv
//  Description : Sequential Fermat inverse a^(Q-2) mod Q over one shared
//                combinational mod-Q multiplier. Build with MODINV_CHECK_EN
//                for the a * a^-1 == 1 self-check state and check_fail port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module km_modinv #(
    parameter int unsigned    W   = 32,
    parameter logic [W-1:0]   Q   = 32'hFFFFD801,
    parameter logic [W-1:0]   EXP = 32'hFFFFD7FF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_inv,
    output logic         zero_err,
    output logic         busy
`ifdef MODINV_CHECK_EN
    ,
    output logic         check_fail
`endif
);

    localparam int unsigned      c_IW      = $clog2(W);
    localparam logic [c_IW-1:0]  c_IDX_TOP = c_IW'(W - 2);
    // 2^W mod Q: the weight each fold applies to the bits above W
    localparam logic [W-1:0]     c_FOLD    = W'({1'b1, {W{1'b0}}} - {1'b0, Q});

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SQR  = 3'd1;
    localparam logic [2:0] c_MUL  = 3'd2;
    localparam logic [2:0] c_DONE = 3'd4;
`ifdef MODINV_CHECK_EN
    localparam logic [2:0] c_CHK  = 3'd3;
    localparam logic [2:0] c_LAST = c_CHK;
`else
    localparam logic [2:0] c_LAST = c_DONE;
`endif

    logic [2:0]      r_state;
    logic [W-1:0]    r_r;
    logic [W-1:0]    r_base;
    logic [c_IW-1:0] r_idx;
    logic            r_zero_err;
`ifdef MODINV_CHECK_EN
    logic            r_check_fail;
`endif

    logic [W-1:0]    w_a_red;
    logic [W-1:0]    w_mul_b;
    logic [W-1:0]    w_mul;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_f1;
    logic [2*W-1:0]  w_f2;
    logic [2*W-1:0]  w_f3;
    logic [2*W-1:0]  w_red;
    logic            w_unused;

    // in_a < 2^W < 2Q, so a single conditional subtraction fully reduces it
    assign w_a_red = (in_a >= Q) ? in_a - Q : in_a;

    // Shared multiplier: squares in SQR, multiplies by base in MUL and CHK
    assign w_mul_b = (r_state == c_SQR) ? r_r : r_base;
    assign w_prod  = {{W{1'b0}}, r_r} * {{W{1'b0}}, w_mul_b};

    // Three folds of the high half bring the product below 2^W for this Q
    assign w_f1  = {{W{1'b0}}, w_prod[2*W-1:W]} * {{W{1'b0}}, c_FOLD}
                 + {{W{1'b0}}, w_prod[W-1:0]};
    assign w_f2  = {{W{1'b0}}, w_f1[2*W-1:W]} * {{W{1'b0}}, c_FOLD}
                 + {{W{1'b0}}, w_f1[W-1:0]};
    assign w_f3  = {{W{1'b0}}, w_f2[2*W-1:W]} * {{W{1'b0}}, c_FOLD}
                 + {{W{1'b0}}, w_f2[W-1:0]};
    assign w_red = (w_f3 >= {{W{1'b0}}, Q}) ? w_f3 - {{W{1'b0}}, Q} : w_f3;
    assign w_mul = w_red[W-1:0];
    assign w_unused = ^w_red[2*W-1:W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_r        <= '0;
            r_base     <= '0;
            r_idx      <= '0;
            r_zero_err <= 1'b0;
`ifdef MODINV_CHECK_EN
            r_check_fail <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
`ifdef MODINV_CHECK_EN
                        r_check_fail <= 1'b0;
`endif
                        if (w_a_red == '0) begin
                            r_r        <= '0;
                            r_zero_err <= 1'b1;
                            r_state    <= c_DONE;
                        end else begin
                            r_base     <= w_a_red;
                            r_r        <= w_a_red;
                            r_idx      <= c_IDX_TOP;
                            r_zero_err <= 1'b0;
                            r_state    <= c_SQR;
                        end
                    end
                end
                c_SQR: begin
                    r_r <= w_mul;
                    if (EXP[r_idx]) begin
                        r_state <= c_MUL;
                    end else if (r_idx == '0) begin
                        r_state <= c_LAST;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                c_MUL: begin
                    r_r <= w_mul;
                    if (r_idx == '0) begin
                        r_state <= c_LAST;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= c_SQR;
                    end
                end
`ifdef MODINV_CHECK_EN
                c_CHK: begin
                    r_check_fail <= (w_mul != W'(1));
                    r_state      <= c_DONE;
                end
`endif
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign out_inv   = (r_state == c_DONE) ? r_r : '0;
    assign zero_err  = r_zero_err;
`ifdef MODINV_CHECK_EN
    assign busy       = (r_state == c_SQR) || (r_state == c_MUL) || (r_state == c_CHK);
    assign check_fail = r_check_fail;
`else
    assign busy       = (r_state == c_SQR) || (r_state == c_MUL);
`endif

endmodule

`default_nettype wire

// File: tb/tb_km_modinv.sv
// ============================================================================
//  Module      : tb_km_modinv
//  Description : Scoreboard bench for km_modinv (Fermat inverse mod Q).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_km_modinv;

    localparam logic [31:0] Q = 32'hFFFFD801;
`ifdef MODINV_CHECK_EN
    localparam int LAT = 61;
`else
    localparam int LAT = 60;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a      = '0;
    wire         in_ready;
    wire         out_valid;
    wire         zero_err;
    wire         busy;
    wire  [31:0] out_inv;
`ifdef MODINV_CHECK_EN
    wire         check_fail;
`endif

    km_modinv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .zero_err  (zero_err),
        .busy      (busy)
`ifdef MODINV_CHECK_EN
        ,
        .check_fail(check_fail)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inv;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          o_lat;
    logic [31:0] o_inv;
    logic        o_zero, o_cf, o_busy_seen, o_ready_seen, o_stable;
    logic        o_ready_after, o_valid_after;

    // Extended Euclid, independent of the exponentiation inside the DUT
    function automatic logic [31:0] ref_inv(input logic [31:0] a);
        longint t = 0, nt = 1, r = longint'(Q), nr = longint'(a), q, tmp;
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + longint'(Q);
        return t[31:0];
    endfunction

    // Drives one operand, waits for the result, holds it 'hold' cycles, then pops it
    task automatic run_op(input logic [31:0] a, input int hold, input bit noise);
        int wait_n = 0;
        while (!in_ready && wait_n < 200) begin
            @(posedge clk); #1; wait_n++;
        end
        in_a = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        o_lat = 0; o_busy_seen = 1'b0; o_ready_seen = 1'b0;
        while (!out_valid && o_lat < 200) begin
            if (busy)     o_busy_seen  = 1'b1;
            if (in_ready) o_ready_seen = 1'b1;
            if (noise) begin in_valid = 1'b1; in_a = $urandom; end
            @(posedge clk); #1; o_lat++;
        end
        in_valid = 1'b0;
        if (busy) o_busy_seen = 1'b1;
        o_inv  = out_inv;
        o_zero = zero_err;
`ifdef MODINV_CHECK_EN
        o_cf = check_fail;
`else
        o_cf = 1'b0;
`endif
        o_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_inv !== o_inv || in_ready) o_stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        o_valid_after = out_valid;
        o_ready_after = in_ready;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_inv !== 32'h0) begin errors++; $display("FAIL reset_out_inv got %h exp 0", out_inv); end
        checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err got %b exp 0", zero_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] ops  [3] = '{32'h1, 32'h2, 32'hFFFFD800};
        logic [31:0] invs [3] = '{32'h1, 32'h7FFFEC01, 32'hFFFFD800};
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{inv: invs[k], zero: 1'b0, lat: LAT});
            run_op(ops[k], 0, 1'b0);
            e = sb.pop_front();
            checks++; if (o_inv !== e.inv) begin errors++; $display("FAIL basic_inv a=%h got %h exp %h", ops[k], o_inv, e.inv); end
            checks++; if (o_zero !== e.zero) begin errors++; $display("FAIL basic_zero a=%h got %b exp %b", ops[k], o_zero, e.zero); end
            checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL basic_latency a=%h got %0d exp %0d", ops[k], o_lat, e.lat); end
            checks++; if (o_busy_seen !== 1'b1 || o_ready_seen !== 1'b0) begin
                errors++; $display("FAIL basic_busy_ready a=%h busy_seen %b ready_seen %b exp 1 0", ops[k], o_busy_seen, o_ready_seen);
            end
            checks++; if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin
                errors++; $display("FAIL basic_release a=%h in_ready %b out_valid %b exp 1 0", ops[k], o_ready_after, o_valid_after);
            end
`ifdef MODINV_CHECK_EN
            checks++; if (o_cf !== 1'b0) begin errors++; $display("FAIL basic_check_fail a=%h got %b exp 0", ops[k], o_cf); end
`endif
        end
    endtask

    task automatic test_zero();
        logic [31:0] ops [2] = '{32'h0, 32'hFFFFD801};
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{inv: 32'h0, zero: 1'b1, lat: 0});
            run_op(ops[k], 0, 1'b0);
            e = sb.pop_front();
            checks++; if (o_inv !== e.inv) begin errors++; $display("FAIL zero_inv a=%h got %h exp %h", ops[k], o_inv, e.inv); end
            checks++; if (o_zero !== e.zero) begin errors++; $display("FAIL zero_err a=%h got %b exp %b", ops[k], o_zero, e.zero); end
            checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL zero_latency a=%h got %0d exp %0d", ops[k], o_lat, e.lat); end
            checks++; if (o_busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy a=%h got %b exp 0", ops[k], o_busy_seen); end
            checks++; if (o_cf !== 1'b0) begin errors++; $display("FAIL zero_check_fail a=%h got %b exp 0", ops[k], o_cf); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        sb.push_back('{inv: 32'h7FFFEC01, zero: 1'b0, lat: LAT});
        run_op(32'h2, 10, 1'b1);
        e = sb.pop_front();
        checks++; if (o_inv !== e.inv) begin errors++; $display("FAIL bp_inv got %h exp %h", o_inv, e.inv); end
        checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL bp_latency got %0d exp %0d", o_lat, e.lat); end
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL bp_hold_stable got %b exp 1", o_stable); end
        checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b exp 1", o_ready_after); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        in_a = 32'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
        sb.push_back('{inv: 32'h7FFFEC01, zero: 1'b0, lat: LAT});
        run_op(32'h2, 0, 1'b0);
        e = sb.pop_front();
        checks++; if (o_inv !== e.inv) begin errors++; $display("FAIL midrst_inv got %h exp %h", o_inv, e.inv); end
        checks++; if (o_lat !== e.lat) begin errors++; $display("FAIL midrst_latency got %0d exp %0d", o_lat, e.lat); end
    endtask

    task automatic test_random();
        logic [31:0] a, ar;
        logic [63:0] p;
        exp_t e;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            while (a == 32'h0 || a == Q) a = $urandom;
            ar = (a >= Q) ? a - Q : a;
            sb.push_back('{inv: ref_inv(ar), zero: 1'b0, lat: LAT});
            run_op(a, 0, 1'b0);
            e = sb.pop_front();
            p = {32'h0, ar} * {32'h0, o_inv};
            checks++; if (o_inv !== e.inv) begin errors++; $display("FAIL rand_inv a=%h got %h exp %h", a, o_inv, e.inv); end
            checks++; if ((p % {32'h0, Q}) !== 64'h1) begin errors++; $display("FAIL rand_product a=%h got %h exp 1", a, p % {32'h0, Q}); end
            checks++; if (o_lat !== e.lat || o_zero !== 1'b0) begin
                errors++; $display("FAIL rand_lat_zero a=%h got lat %0d zero %b exp %0d 0", a, o_lat, o_zero, e.lat);
            end
`ifdef MODINV_CHECK_EN
            checks++; if (o_cf !== 1'b0) begin errors++; $display("FAIL rand_check_fail a=%h got %b exp 0", a, o_cf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
